// File: rtl/step_pulse_gen_pkg.sv
// ============================================================================
//  Module      : step_pulse_gen_pkg
//  Description : Shared definitions for the step-pulse transmitter: FSM state
//                encoding, system clock rate, tracker step-counter width and
//                the minimum-spacing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package step_pulse_gen_pkg;

  localparam int unsigned CLK_HZ         = 100_000_000;
  // Width of the downstream tracker's step counter; COUNT_W defaults to it
  localparam int unsigned TRACKER_STEP_W = 14;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HIGH = ST_HIGH,
    LOW  = ST_LOW,
    DONE = ST_DONE
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Rising edges must be at least one low cycle apart: max(period, pulse_w+1)
  function automatic int unsigned clamp_period(input int unsigned period,
                                               input int unsigned pulse_w);
    return (period > pulse_w) ? period : pulse_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_pulse_gen_if.sv
// ============================================================================
//  Module      : step_pulse_gen_if
//  Description : Control/status bundle of the step-pulse transmitter. The
//                master issues bursts; the slave (the generator) drives the
//                pulse output and progress status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface step_pulse_gen_if #(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned COUNT_W  = 14
);

  logic                start;
  logic                abort;
  logic [PERIOD_W-1:0] period;
  logic [COUNT_W-1:0]  num_steps;
  logic                pulseSignal;
  logic                busy;
  logic                done;
  logic [COUNT_W-1:0]  sent_count;

  modport master (
    output start, abort, period, num_steps,
    input  pulseSignal, busy, done, sent_count
  );

  modport slave (
    input  start, abort, period, num_steps,
    output pulseSignal, busy, done, sent_count
  );

endinterface

`default_nettype wire

// File: rtl/step_lfsr.sv
// ============================================================================
//  Module      : step_lfsr
//  Description : 8-bit Fibonacci LFSR (taps 8,6,5,4), advances when en_i is
//                high, reseeds to 8'hA5 on reset. Supplies spacing jitter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_lfsr
  import step_pulse_gen_pkg::*;
(
  input  logic       clk100Mhz,
  input  logic       rst,
  input  logic       en_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic       fb;

  assign fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign lfsr_o = lfsr_q;

  // Shift in the feedback bit once per enable; never reaches the all-zero lock state
  always_ff @(posedge clk100Mhz or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (en_i) begin
      lfsr_q <= {lfsr_q[6:0], fb};
    end
  end

endmodule

`default_nettype wire

// File: rtl/step_pulse_gen.sv
// ============================================================================
//  Module      : step_pulse_gen
//  Description : Programmable step-pulse transmitter. On an accepted start it
//                emits num_steps pulses, PULSE_W cycles high, rising edges
//                max(period, PULSE_W+1) cycles apart, then strobes done.
//                Optional macro STEP_JITTER_EN lengthens each low phase by
//                0..7 cycles taken from an LFSR.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned COUNT_W  = TRACKER_STEP_W,
  parameter int unsigned PULSE_W  = 1
) (
  input  logic            clk100Mhz,
  input  logic            rst,
  step_pulse_gen_if.slave bus
);

  localparam logic [PERIOD_W-1:0] PW_CYC = PERIOD_W'(PULSE_W);
  localparam logic [PERIOD_W-1:0] ONE    = PERIOD_W'(1);

  state_e              state_q;
  logic                pulse_q;
  logic                busy_q;
  logic                done_q;
  logic [COUNT_W-1:0]  sent_q;
  logic [COUNT_W-1:0]  steps_q;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] cnt_q;     // cycles left in the current phase, ends at 1
  logic [PERIOD_W-1:0] per_d;
  logic [PERIOD_W-1:0] low_cycles;

  assign per_d      = PERIOD_W'(clamp_period(32'(bus.period), PULSE_W));
  assign low_cycles = per_q - PW_CYC;

`ifdef STEP_JITTER_EN
  logic [7:0] lfsr;
  logic [2:0] jit_q;
  logic       lfsr_adv;

  // Advance once per pulse, on the edge that raises pulseSignal
  assign lfsr_adv = (state_q == LOW) && !bus.abort && (cnt_q == ONE) &&
                    (jit_q == 3'd0) && (sent_q < steps_q);

  step_lfsr u_lfsr (
    .clk100Mhz (clk100Mhz),
    .rst       (rst),
    .en_i      (lfsr_adv),
    .lfsr_o    (lfsr)
  );
`endif

  // Burst sequencer. An accepted start enters a one-cycle lead-in LOW so the
  // first rising edge lands one cycle after acceptance; a zero-step burst
  // leaves that lead-in straight to DONE without pulsing.
  always_ff @(posedge clk100Mhz or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sent_q  <= '0;
      steps_q <= '0;
      per_q   <= '0;
      cnt_q   <= '0;
`ifdef STEP_JITTER_EN
      jit_q   <= 3'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_q <= LOW;
            per_q   <= per_d;
            steps_q <= bus.num_steps;
            sent_q  <= '0;
            busy_q  <= 1'b1;
            cnt_q   <= ONE;
`ifdef STEP_JITTER_EN
            jit_q   <= 3'd0;
`endif
          end
        end
        HIGH: begin
          if (bus.abort) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt_q != ONE) begin
            cnt_q <= cnt_q - ONE;
          end else begin
            state_q <= LOW;
            pulse_q <= 1'b0;
            cnt_q   <= low_cycles;
`ifdef STEP_JITTER_EN
            jit_q   <= lfsr[2:0];
`endif
          end
        end
        LOW: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q != ONE) begin
            cnt_q <= cnt_q - ONE;
`ifdef STEP_JITTER_EN
          end else if (jit_q != 3'd0) begin
            jit_q <= jit_q - 3'd1;
`endif
          end else if (sent_q < steps_q) begin
            state_q <= HIGH;
            pulse_q <= 1'b1;
            sent_q  <= sent_q + COUNT_W'(1);
            cnt_q   <= PW_CYC;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.pulseSignal = pulse_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.sent_count  = sent_q;

endmodule

`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
// ============================================================================
//  Module      : tb_step_pulse_gen
//  Description : Self-checking bench for step_pulse_gen. Expected waveforms
//                are computed arithmetically from burst parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_step_pulse_gen;

  localparam int PERIOD_W = 24;
  localparam int COUNT_W  = 14;
  localparam int PW       = 1;

  logic clk100Mhz = 1'b0;
  logic rst       = 1'b1;
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   idle_sent = 0;

  step_pulse_gen_if #(.PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) bus ();

  step_pulse_gen #(.PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W), .PULSE_W(PW)) dut (
    .clk100Mhz (clk100Mhz),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk100Mhz = ~clk100Mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input int want);
    n_cmp++;
    assert (obs === 32'(want))
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk100Mhz);
    #1;
  endtask

  function automatic int spacing(input int period);
    return (period >= PW + 1) ? period : PW + 1;
  endfunction

  // Pulses whose rising edge has happened by k cycles after the accept edge
  function automatic int rises(input int k, input int per, input int s);
    int r;
    if (k < 1) return 0;
    r = (k - 1) / per + 1;
    return (r < s) ? r : s;
  endfunction

  // Expected outputs k cycles after the accept edge; ak = abort edge (0: none)
  task automatic model(input int k, input int per, input int s, input int ak,
                       output int ep, output int eb, output int ed, output int es);
    if (ak > 0 && k >= ak) begin
      ep = 0; eb = 0; ed = 0;
      es = rises(ak - 1, per, s);
    end else begin
      ep = int'(k >= 1 && (k - 1) / per < s && (k - 1) % per < PW);
      eb = int'(k <= s * per);
      ed = int'(k == s * per + 1);
      es = rises(k, per, s);
    end
  endtask

  // One burst: issue start, then check every cycle until a few cycles past
  // completion (or abort). noise scrambles start/period/num_steps mid-burst.
  task automatic run_burst(input int period, input int s, input int ak, input bit noise);
    int per, last, ep, eb, ed, es;
    per = spacing(period);
    last = (ak > 0) ? ak + 3 : s * per + 3;
    bus.start     = 1'b1;
    bus.abort     = 1'b0;
    bus.period    = PERIOD_W'(period);
    bus.num_steps = COUNT_W'(s);
    tick();
    for (int k = 0; k <= last; k++) begin
      model(k, per, s, ak, ep, eb, ed, es);
      chk($sformatf("pulse@%0d", k), 32'(bus.pulseSignal), ep);
      chk($sformatf("busy@%0d", k),  32'(bus.busy), eb);
      chk($sformatf("done@%0d", k),  32'(bus.done), ed);
      chk($sformatf("sent@%0d", k),  32'(bus.sent_count), es);
      idle_sent = es;
      bus.start = noise && ak == 0 && (k + 1 <= s * per + 1) && ($urandom_range(0, 5) == 0);
      if (noise) begin
        bus.period    = PERIOD_W'($urandom_range(1, 40));
        bus.num_steps = COUNT_W'($urandom_range(0, 40));
      end
      bus.abort = (ak > 0 && k + 1 == ak);
      if (k < last) tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.period    = '0;
    bus.num_steps = '0;

    // Reset state
    #2 rst = 1'b0;
    repeat (3) tick();
    chk("rst_pulse", 32'(bus.pulseSignal), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_sent",  32'(bus.sent_count), 0);
    rst = 1'b1;
    tick();

    // Basic bursts, then start with abort in IDLE is dropped
    run_burst(4, 3, 0, 0);
    bus.start = 1'b1; bus.abort = 1'b1; bus.period = 24'd5; bus.num_steps = 14'd3;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("idle_abort_busy",  32'(bus.busy), 0);
    chk("idle_abort_pulse", 32'(bus.pulseSignal), 0);
    tick();
    chk("idle_abort_busy2", 32'(bus.busy), 0);
    chk("idle_abort_sent",  32'(bus.sent_count), idle_sent);

    // Zero steps, period clamp, abort in 5th LOW phase
    run_burst(7, 0, 0, 0);
    run_burst(1, 9, 0, 1);
    run_burst(0, 4, 0, 0);
    begin
      int per;
      per = $urandom_range(3, 10);
      run_burst(per, 8, 4 * per + 3, 0);
    end

    // Randomized bursts with mid-burst noise, and random aborts
    for (int i = 0; i < 8; i++)
      run_burst($urandom_range(1, 12), $urandom_range(0, 20), 0, 1);
    for (int i = 0; i < 4; i++) begin
      int p, s;
      p = $urandom_range(1, 9);
      s = $urandom_range(2, 12);
      run_burst(p, s, $urandom_range(2, s * spacing(p)), 0);
    end

    // Reset asserted during a HIGH phase acts without a clock edge
    bus.start = 1'b1; bus.period = 24'd4; bus.num_steps = 14'd5;
    tick();
    bus.start = 1'b0;
    chk("prerst_busy", 32'(bus.busy), 1);
    tick();
    chk("prerst_pulse", 32'(bus.pulseSignal), 1);
    chk("prerst_sent",  32'(bus.sent_count), 1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_pulse", 32'(bus.pulseSignal), 0);
    chk("async_rst_busy",  32'(bus.busy), 0);
    chk("async_rst_sent",  32'(bus.sent_count), 0);
    chk("async_rst_done",  32'(bus.done), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    run_burst(6, 4, 0, 1);

    // Long bursts back to back: count restarts from zero
    run_burst(10, 3000, 0, 0);
    run_burst(10, 800, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, observed %0d compared, expected completion", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
